// File: rtl/icache_mshr_ctrl_if.sv
// ----------------------------------------------------------------------------
// icache_mshr_ctrl_if
// Bundle of every non-clock/reset signal of the icache MSHR controller.
//   slave  modport : the MSHR controller (consumes lookups, drives requests)
//   master modport : the surrounding tag controller / downstream / bench
// Groups:
//   alloc_*          entry allocation handshake with the tag controller
//   upd_*            per-lookup hit/miss result and request payload
//   ds_req_*/ds_rsp_* downstream line-fill request and completion
//   rd_done_*        data-RAM read completion for hit entries
//   entry_*          per-entry conflict-bitmap vectors
//   linefill_done, release_*, proto_err  notifications
// ----------------------------------------------------------------------------
interface icache_mshr_ctrl_if #(
  parameter int unsigned ENTRY_NUM   = 8,
  parameter int unsigned ENTRY_IDX_W = 3,
  parameter int unsigned INDEX_W     = 7,
  parameter int unsigned TAG_W       = 20,
  parameter int unsigned TXNID_W     = 5
);
  logic                           alloc_vld;
  logic                           alloc_rdy;
  logic [ENTRY_IDX_W-1:0]         alloc_index;
  logic                           upd_en;
  logic                           upd_miss;
  logic                           upd_way;
  logic [TAG_W-1:0]               upd_tag;
  logic [INDEX_W-1:0]             upd_index;
  logic [TXNID_W-1:0]             upd_txnid;
  logic                           ds_req_vld;
  logic                           ds_req_rdy;
  logic [TAG_W+INDEX_W-1:0]       ds_req_addr;
  logic [ENTRY_IDX_W-1:0]         ds_req_id;
  logic                           ds_rsp_vld;
  logic [ENTRY_IDX_W-1:0]         ds_rsp_id;
  logic                           rd_done_vld;
  logic [ENTRY_IDX_W-1:0]         rd_done_id;
  logic [ENTRY_NUM-1:0]           entry_valid;
  logic [ENTRY_NUM*INDEX_W-1:0]   entry_index;
  logic [ENTRY_NUM-1:0]           entry_way;
  logic [ENTRY_NUM-1:0]           linefill_done;
  logic                           release_vld;
  logic [ENTRY_IDX_W-1:0]         release_index;
  logic [TXNID_W-1:0]             release_txnid;
  logic                           proto_err;

  modport slave (
    input  alloc_vld, upd_en, upd_miss, upd_way, upd_tag, upd_index, upd_txnid,
           ds_req_rdy, ds_rsp_vld, ds_rsp_id, rd_done_vld, rd_done_id,
    output alloc_rdy, alloc_index, ds_req_vld, ds_req_addr, ds_req_id,
           entry_valid, entry_index, entry_way, linefill_done,
           release_vld, release_index, release_txnid, proto_err
  );

  modport master (
    output alloc_vld, upd_en, upd_miss, upd_way, upd_tag, upd_index, upd_txnid,
           ds_req_rdy, ds_rsp_vld, ds_rsp_id, rd_done_vld, rd_done_id,
    input  alloc_rdy, alloc_index, ds_req_vld, ds_req_addr, ds_req_id,
           entry_valid, entry_index, entry_way, linefill_done,
           release_vld, release_index, release_txnid, proto_err
  );
endinterface

// File: rtl/icache_mshr_ctrl.sv
// ----------------------------------------------------------------------------
// icache_mshr_ctrl
// Miss-status holding register file behind the icache tag controller.
// Hands out free entries, captures hit/miss results, issues line-fill
// requests for misses, tracks completions and retires entries.
// Ports:
//   clk    clock (posedge)
//   rst_n  asynchronous active-low reset
//   mshr   icache_mshr_ctrl_if.slave (allocation, lookup result, downstream
//          request/response, read-done, per-entry vectors, release, proto_err)
// Build option:
//   ICACHE_MSHR_RR_ARB_EN  round-robin downstream request arbitration;
//                          otherwise lowest MISS_REQ index wins.
// ----------------------------------------------------------------------------
module icache_mshr_ctrl #(
  parameter int unsigned ENTRY_NUM   = 8,
  parameter int unsigned ENTRY_IDX_W = 3,
  parameter int unsigned INDEX_W     = 7,
  parameter int unsigned TAG_W       = 20,
  parameter int unsigned TXNID_W     = 5
) (
  input logic               clk,
  input logic               rst_n,
  icache_mshr_ctrl_if.slave mshr
);

  typedef enum logic [2:0] {
    IDLE,
    RSV,
    HIT_WAIT,
    MISS_REQ,
    MISS_WAIT,
    REL
  } state_e;

  state_e                 state_q [ENTRY_NUM];
  state_e                 state_d [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]   valid_q, valid_d;
  logic [ENTRY_NUM-1:0]   fill_q, fill_d;

  logic [TAG_W-1:0]       tag_q   [ENTRY_NUM];
  logic [INDEX_W-1:0]     index_q [ENTRY_NUM];
  logic [TXNID_W-1:0]     txnid_q [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]   way_q;

  logic                   free_found, rsv_found, rel_found, arb_found;
  logic [ENTRY_IDX_W-1:0] free_idx, rsv_idx, rel_idx, arb_idx, arb_base;
  logic                   req_vld, req_acc;
  logic [ENTRY_IDX_W-1:0] req_id;
  logic                   hold_q;
  logic [ENTRY_IDX_W-1:0] hold_id_q;
  logic                   err_set, proto_err_q;

`ifdef ICACHE_MSHR_RR_ARB_EN
  logic [ENTRY_IDX_W-1:0] rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (req_acc) begin
      rr_ptr_q <= req_id + ENTRY_IDX_W'(1);
    end
  end

  assign arb_base = rr_ptr_q;
`else
  assign arb_base = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) state_q[i] <= IDLE;
      valid_q     <= '0;
      fill_q      <= '0;
      hold_q      <= 1'b0;
      hold_id_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) state_q[i] <= state_d[i];
      valid_q     <= valid_d;
      fill_q      <= fill_d;
      // A request left unaccepted is pinned so id/addr cannot change under it
      // when a higher-priority entry enters MISS_REQ.
      hold_q      <= req_vld & ~mshr.ds_req_rdy;
      hold_id_q   <= req_id;
      proto_err_q <= proto_err_q | err_set;
    end
  end

  // Per-entry payload, latched with the lookup result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        tag_q[i]   <= '0;
        index_q[i] <= '0;
        txnid_q[i] <= '0;
      end
      way_q <= '0;
    end else if (mshr.upd_en && rsv_found) begin
      tag_q[rsv_idx]   <= mshr.upd_tag;
      index_q[rsv_idx] <= mshr.upd_index;
      txnid_q[rsv_idx] <= mshr.upd_txnid;
      way_q[rsv_idx]   <= mshr.upd_way;
    end
  end

  // Next-state logic
  always_comb begin
    valid_d = '0;
    fill_d  = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:
          if (mshr.alloc_vld && free_found && free_idx == ENTRY_IDX_W'(i))
            state_d[i] = RSV;
        RSV:
          if (mshr.upd_en) state_d[i] = mshr.upd_miss ? MISS_REQ : HIT_WAIT;
          else             state_d[i] = IDLE;
        MISS_REQ:
          if (req_acc && req_id == ENTRY_IDX_W'(i)) state_d[i] = MISS_WAIT;
        MISS_WAIT:
          if (mshr.ds_rsp_vld && mshr.ds_rsp_id == ENTRY_IDX_W'(i)) begin
            state_d[i] = REL;
            fill_d[i]  = 1'b1;
          end
        HIT_WAIT:
          if (mshr.rd_done_vld && mshr.rd_done_id == ENTRY_IDX_W'(i))
            state_d[i] = REL;
        REL:
          if (rel_found && rel_idx == ENTRY_IDX_W'(i)) state_d[i] = IDLE;
        default:
          state_d[i] = IDLE;
      endcase
      valid_d[i] = state_d[i] inside {HIT_WAIT, MISS_REQ, MISS_WAIT, REL};
    end
  end

  // Output / selection logic, all from registered state
  always_comb begin
    logic [ENTRY_IDX_W-1:0] cand;
    cand       = '0;
    free_found = 1'b0;
    free_idx   = '0;
    rsv_found  = 1'b0;
    rsv_idx    = '0;
    rel_found  = 1'b0;
    rel_idx    = '0;
    arb_found  = 1'b0;
    arb_idx    = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!free_found && state_q[i] == IDLE) begin
        free_found = 1'b1;
        free_idx   = ENTRY_IDX_W'(i);
      end
      // RSV lasts exactly one cycle, so at most one entry is ever in it.
      if (state_q[i] == RSV) begin
        rsv_found = 1'b1;
        rsv_idx   = ENTRY_IDX_W'(i);
      end
      if (!rel_found && state_q[i] == REL) begin
        rel_found = 1'b1;
        rel_idx   = ENTRY_IDX_W'(i);
      end
    end
    for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
      cand = arb_base + ENTRY_IDX_W'(k);
      if (!arb_found && state_q[cand] == MISS_REQ) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    req_vld = hold_q | arb_found;
    req_id  = hold_q ? hold_id_q : arb_idx;
    req_acc = req_vld & mshr.ds_req_rdy;
    err_set = (mshr.upd_en & ~rsv_found)
            | (mshr.ds_rsp_vld  & (state_q[mshr.ds_rsp_id]  != MISS_WAIT))
            | (mshr.rd_done_vld & (state_q[mshr.rd_done_id] != HIT_WAIT));
  end

  always_comb begin
    mshr.entry_index = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++)
      mshr.entry_index[i*INDEX_W +: INDEX_W] = index_q[i];
  end

  assign mshr.alloc_rdy     = free_found;
  assign mshr.alloc_index   = free_idx;
  assign mshr.ds_req_vld    = req_vld;
  assign mshr.ds_req_id     = req_id;
  assign mshr.ds_req_addr   = {tag_q[req_id], index_q[req_id]};
  assign mshr.entry_valid   = valid_q;
  assign mshr.entry_way     = way_q;
  assign mshr.linefill_done = fill_q;
  assign mshr.release_vld   = rel_found;
  assign mshr.release_index = rel_idx;
  assign mshr.release_txnid = rel_found ? txnid_q[rel_idx] : '0;
  assign mshr.proto_err     = proto_err_q;

endmodule

// File: tb/tb_icache_mshr_ctrl.sv
module tb_icache_mshr_ctrl;
  localparam int N = 8, IW = 3, XW = 7, TW = 20, TXW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_mshr_ctrl_if #(.ENTRY_NUM(N), .ENTRY_IDX_W(IW), .INDEX_W(XW),
                        .TAG_W(TW), .TXNID_W(TXW)) bus ();

  icache_mshr_ctrl #(.ENTRY_NUM(N), .ENTRY_IDX_W(IW), .INDEX_W(XW),
                     .TAG_W(TW), .TXNID_W(TXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mshr  (bus)
  );

  // Reference model: entries tracked as membership sets
  bit              m_free[N], m_req[N], m_fill[N], m_read[N], m_ret[N], m_lfd[N];
  int              m_rsv, m_held_id, m_rr;
  bit              m_held, m_perr;
  logic [TW-1:0]   m_tag[N];
  logic [XW-1:0]   m_idx[N];
  logic [TXW-1:0]  m_txn[N];
  bit              m_way[N];

  bit e_alloc_rdy, e_ds_vld, e_rel_vld;
  int e_alloc_idx, e_ds_id, e_rel_idx;

  int n_total = 0, n_pass = 0;

  function automatic int lowest(input bit v[N]);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int pick(input bit v[N]);
    int c[$];
    for (int i = 0; i < N; i++) if (v[i]) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(c.size() - 1, 0)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_free[i] = 1; m_req[i] = 0; m_fill[i] = 0; m_read[i] = 0;
      m_ret[i] = 0; m_lfd[i] = 0;
    end
    m_rsv = -1; m_held = 0; m_held_id = 0; m_rr = 0; m_perr = 0;
  endtask

  function automatic void compute_exp();
    int i, base;
    i = lowest(m_free);
    e_alloc_rdy = (i >= 0);
    e_alloc_idx = (i < 0) ? 0 : i;
    if (m_held) begin
      e_ds_vld = 1; e_ds_id = m_held_id;
    end else begin
`ifdef ICACHE_MSHR_RR_ARB_EN
      base = m_rr;
`else
      base = 0;
`endif
      e_ds_vld = 0; e_ds_id = 0;
      for (int k = 0; k < N; k++)
        if (!e_ds_vld && m_req[(base + k) % N]) begin
          e_ds_vld = 1; e_ds_id = (base + k) % N;
        end
    end
    i = lowest(m_ret);
    e_rel_vld = (i >= 0);
    e_rel_idx = (i < 0) ? 0 : i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]    ev, lf, wm, we;
    logic [N*XW-1:0] im, ie;
    compute_exp();
    ev = '0; lf = '0; wm = '0; we = '0; im = '0; ie = '0;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_req[i] | m_fill[i] | m_read[i] | m_ret[i];
      lf[i] = m_lfd[i];
      if (ev[i]) begin
        wm[i] = 1'b1; we[i] = m_way[i];
        im[i*XW +: XW] = '1; ie[i*XW +: XW] = m_idx[i];
      end
    end
    chk("alloc_rdy", 64'(bus.alloc_rdy), 64'(e_alloc_rdy));
    if (e_alloc_rdy) chk("alloc_index", 64'(bus.alloc_index), 64'(e_alloc_idx));
    chk("ds_req_vld", 64'(bus.ds_req_vld), 64'(e_ds_vld));
    if (e_ds_vld) begin
      chk("ds_req_id", 64'(bus.ds_req_id), 64'(e_ds_id));
      chk("ds_req_addr", 64'(bus.ds_req_addr), 64'({m_tag[e_ds_id], m_idx[e_ds_id]}));
    end
    chk("release_vld", 64'(bus.release_vld), 64'(e_rel_vld));
    chk("release_index", 64'(bus.release_index), 64'(e_rel_idx));
    chk("release_txnid", 64'(bus.release_txnid), e_rel_vld ? 64'(m_txn[e_rel_idx]) : 64'd0);
    chk("entry_valid", 64'(bus.entry_valid), 64'(ev));
    chk("linefill_done", 64'(bus.linefill_done), 64'(lf));
    chk("entry_index", 64'(bus.entry_index & im), 64'(ie));
    chk("entry_way", 64'(bus.entry_way & wm), 64'(we));
    chk("proto_err", 64'(bus.proto_err), 64'(m_perr));
  endtask

  task automatic model_step();
    bit n_lfd[N];
    int new_rsv, j;
    compute_exp();
    for (int i = 0; i < N; i++) n_lfd[i] = 0;
    new_rsv = -1;
    if (bus.ds_rsp_vld) begin
      j = int'(bus.ds_rsp_id);
      if (m_fill[j]) begin m_fill[j] = 0; m_ret[j] = 1; n_lfd[j] = 1; end
      else m_perr = 1;
    end
    if (bus.rd_done_vld) begin
      j = int'(bus.rd_done_id);
      if (m_read[j]) begin m_read[j] = 0; m_ret[j] = 1; end
      else m_perr = 1;
    end
    if (e_rel_vld) begin m_ret[e_rel_idx] = 0; m_free[e_rel_idx] = 1; end
    if (e_ds_vld) begin
      if (bus.ds_req_rdy) begin
        m_req[e_ds_id] = 0; m_fill[e_ds_id] = 1; m_held = 0; m_rr = (e_ds_id + 1) % N;
      end else begin
        m_held = 1; m_held_id = e_ds_id;
      end
    end
    if (bus.upd_en) begin
      if (m_rsv < 0) m_perr = 1;
      else begin
        m_tag[m_rsv] = bus.upd_tag; m_idx[m_rsv] = bus.upd_index;
        m_txn[m_rsv] = bus.upd_txnid; m_way[m_rsv] = bus.upd_way;
        if (bus.upd_miss) m_req[m_rsv] = 1; else m_read[m_rsv] = 1;
      end
    end else if (m_rsv >= 0) begin
      m_free[m_rsv] = 1;
    end
    if (bus.alloc_vld && e_alloc_rdy) begin
      m_free[e_alloc_idx] = 0; new_rsv = e_alloc_idx;
    end
    m_rsv = new_rsv;
    m_lfd = n_lfd;
  endtask

  task automatic idle_in();
    bus.alloc_vld = 0; bus.upd_en = 0; bus.upd_miss = 0; bus.upd_way = 0;
    bus.upd_tag = '0; bus.upd_index = '0; bus.upd_txnid = '0;
    bus.ds_req_rdy = 0; bus.ds_rsp_vld = 0; bus.ds_rsp_id = '0;
    bus.rd_done_vld = 0; bus.rd_done_id = '0;
  endtask

  task automatic set_upd(input bit miss, input bit way, input logic [TW-1:0] tag,
                         input logic [XW-1:0] idx, input logic [TXW-1:0] txn);
    bus.upd_en = 1; bus.upd_miss = miss; bus.upd_way = way;
    bus.upd_tag = tag; bus.upd_index = idx; bus.upd_txnid = txn;
  endtask

  // Called at a falling edge with inputs set; checks, advances model, waits one cycle
  task automatic tick();
    #2;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic gen_random();
    int j;
    idle_in();
    bus.alloc_vld = ($urandom_range(99, 0) < 60);
    if (m_rsv >= 0 && $urandom_range(99, 0) < 85)
      set_upd(1'($urandom), 1'($urandom), TW'($urandom), XW'($urandom), TXW'($urandom));
    bus.ds_req_rdy = ($urandom_range(99, 0) < 50);
    j = pick(m_fill);
    if (j >= 0 && $urandom_range(1, 0) == 1) begin bus.ds_rsp_vld = 1; bus.ds_rsp_id = IW'(j); end
    j = pick(m_read);
    if (j >= 0 && $urandom_range(1, 0) == 1) begin bus.rd_done_vld = 1; bus.rd_done_id = IW'(j); end
  endtask

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1;

    // Miss path with minimum latency
    bus.alloc_vld = 1; tick(); idle_in();
    set_upd(1, 1, 20'h12345, 7'h05, 5'h0a); bus.ds_req_rdy = 1; tick(); idle_in();
    bus.ds_req_rdy = 1;
    #1 chk("t1_ds_addr", 64'(bus.ds_req_addr), 64'({20'h12345, 7'h05}));
    tick();
    repeat (6) tick();
    bus.ds_rsp_vld = 1; bus.ds_rsp_id = 0; tick(); idle_in();
    #1 chk("t1_linefill", 64'(bus.linefill_done), 64'h01);
    chk("t1_release", 64'({bus.release_vld, bus.release_index}), 64'h8);
    tick();
    #1 chk("t1_realloc", 64'({bus.alloc_rdy, bus.alloc_index}), 64'h8);
    tick();

    // Hit path
    bus.alloc_vld = 1; tick(); idle_in();
    set_upd(0, 0, 20'h0abcd, 7'h11, 5'h15); tick(); idle_in();
    bus.rd_done_vld = 1; bus.rd_done_id = 0;
    #1 chk("t2_no_ds_req", 64'(bus.ds_req_vld), 64'd0);
    tick(); idle_in();
    #1 chk("t2_rel_txnid", 64'({bus.release_vld, bus.release_txnid}), 64'h35);
    tick();

    // Allocation with no lookup result
    bus.alloc_vld = 1; tick(); idle_in();
    tick();
    #1 chk("t4_reuse", 64'({bus.alloc_index, bus.entry_valid}), 64'd0);
    tick();

    // Fill all entries while downstream stalls, then drain in order
    for (int e = 0; e <= 8; e++) begin
      idle_in();
      if (e < 8) bus.alloc_vld = 1;
      if (e > 0) set_upd(1, 1'($urandom), TW'($urandom), XW'($urandom), TXW'(e));
      if (e == 8) begin #1 chk("t3_full", 64'(bus.alloc_rdy), 64'd0); end
      tick();
    end
    for (int e = 0; e < 8; e++) begin
      idle_in(); bus.ds_req_rdy = 1;
      #1 chk("t3_order", 64'(bus.ds_req_id), 64'(e));
      tick();
    end
    for (int e = 0; e < 8; e++) begin
      idle_in(); bus.ds_rsp_vld = 1; bus.ds_rsp_id = IW'(e); tick();
    end
    idle_in(); repeat (3) tick();

    // Entries 2 and 5 reach release together
    for (int e = 0; e <= 6; e++) begin
      idle_in(); bus.ds_req_rdy = 1;
      if (e < 6) bus.alloc_vld = 1;
      if (e > 0) set_upd(e == 6, 1'(e), TW'(e * 3), XW'(e + 40), TXW'(e + 16));
      tick();
    end
    foreach (m_free[k]) begin
      if (k == 0 || k == 1 || k == 3 || k == 4) begin
        idle_in(); bus.ds_req_rdy = 1; bus.rd_done_vld = 1; bus.rd_done_id = IW'(k); tick();
      end
    end
    idle_in(); bus.rd_done_vld = 1; bus.rd_done_id = 2; bus.ds_rsp_vld = 1; bus.ds_rsp_id = 5;
    tick(); idle_in();
    #1 chk("t6_rel_first", 64'({bus.release_vld, bus.release_index}), 64'ha);
    tick();
    #1 chk("t6_rel_second", 64'({bus.release_vld, bus.release_index}), 64'hd);
    tick();
    idle_in(); repeat (2) tick();

    // Stray response alongside a legitimate read completion
    bus.alloc_vld = 1; tick(); idle_in();
    set_upd(0, 1, 20'h00777, 7'h22, 5'h07); tick(); idle_in();
    bus.rd_done_vld = 1; bus.rd_done_id = 0; bus.ds_rsp_vld = 1; bus.ds_rsp_id = 6;
    tick(); idle_in();
    #1 chk("t5_perr_rel", 64'({bus.proto_err, bus.release_vld, bus.release_txnid}), 64'h67);
    tick();

    // Randomized traffic against the model
    repeat (800) begin
      gen_random();
      tick();
    end

    // Reset mid-operation, then a late response
    idle_in();
    rst_n = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    bus.ds_rsp_vld = 1; bus.ds_rsp_id = 3; tick(); idle_in();
    #1 chk("late_rsp_perr", 64'(bus.proto_err), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
